// File: rtl/io_timer.sv
// rtl/io_timer.sv - memory-mapped prescaled countdown timer with sticky expiry status
module io_timer #(
    parameter int PRESCALE = 1000
) (
    input  logic        clock,
    input  logic        rst,
    input  logic        timercs,
    input  logic [1:0]  timeraddr,
    input  logic        timerread,
    input  logic        timerwrite,
    input  logic [15:0] timerwdata,
    output logic [15:0] timerrdata,
    output logic        timeout,
    output logic        running
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [1:0]  ADDR_CTRL   = 2'd0;
    localparam logic [1:0]  ADDR_RELOAD = 2'd1;
    localparam logic [1:0]  ADDR_COUNT  = 2'd2;
    localparam logic [1:0]  ADDR_STATUS = 2'd3;
    localparam logic [15:0] PS_LAST     = 16'(PRESCALE - 1);

    state_t      state, state_n;
    logic        ctrl_en, ctrl_en_n;
    logic        ctrl_ar, ctrl_ar_n;
    logic [15:0] reload_q, reload_n;
    logic [15:0] count_q, count_n;
    logic [15:0] presc_q, presc_n;
    logic        expired_q, expired_n;
    logic [7:0]  miss_q, miss_n;
    logic        timeout_n;
    logic        expire;

    logic wr_ctrl, wr_reload, rd_status, stop_req, tick;

    assign wr_ctrl   = timercs && timerwrite && (timeraddr == ADDR_CTRL);
    assign wr_reload = timercs && timerwrite && (timeraddr == ADDR_RELOAD);
    assign rd_status = timercs && timerread  && (timeraddr == ADDR_STATUS);
    // A CTRL write with enable low pauses a running timer and cancels a pending start.
    assign stop_req  = wr_ctrl && !timerwdata[0];
    assign tick      = (presc_q == PS_LAST);
    assign running   = (state == RUN);

    // Register file, counters and FSM state.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ctrl_en   <= 1'b0;
            ctrl_ar   <= 1'b0;
            reload_q  <= 16'h0000;
            count_q   <= 16'h0000;
            presc_q   <= 16'h0000;
            expired_q <= 1'b0;
            miss_q    <= 8'h00;
            timeout   <= 1'b0;
        end else begin
            state     <= state_n;
            ctrl_en   <= ctrl_en_n;
            ctrl_ar   <= ctrl_ar_n;
            reload_q  <= reload_n;
            count_q   <= count_n;
            presc_q   <= presc_n;
            expired_q <= expired_n;
            miss_q    <= miss_n;
            timeout   <= timeout_n;
        end
    end

    // Next-state: countdown, expiry handling, then bus writes which take priority.
    always_comb begin
        state_n   = state;
        ctrl_en_n = ctrl_en;
        ctrl_ar_n = ctrl_ar;
        reload_n  = reload_q;
        count_n   = count_q;
        presc_n   = presc_q;
        expired_n = expired_q;
        miss_n    = miss_q;
        timeout_n = 1'b0;
        expire    = 1'b0;

        if (rd_status) begin
            expired_n = 1'b0;
            miss_n    = 8'h00;
        end
        if (wr_reload) begin
            reload_n = timerwdata;
        end

        unique case (state)
            IDLE: begin
                if (ctrl_en && !stop_req) begin
                    presc_n = 16'h0000;
                    if (count_q != 16'h0000) begin
                        state_n = RUN;
                    end else if (reload_q != 16'h0000) begin
                        count_n = reload_q;
                        state_n = RUN;
                    end else begin
                        // Nothing to count: expire immediately without entering RUN.
                        expire    = 1'b1;
                        ctrl_en_n = 1'b0;
                    end
                end
            end
            RUN: begin
                if (stop_req) begin
                    // Pause: count and prescaler hold, any tick this edge is dropped.
                    state_n = IDLE;
                end else if (tick) begin
                    presc_n = 16'h0000;
                    if (count_q > 16'd1) begin
                        count_n = count_q - 16'd1;
                    end else begin
                        expire = 1'b1;
                        if (ctrl_ar && (reload_q != 16'h0000)) begin
                            count_n = reload_q;
                        end else begin
                            count_n   = 16'h0000;
                            state_n   = IDLE;
                            ctrl_en_n = 1'b0;
                        end
                    end
                end else begin
                    presc_n = presc_q + 16'd1;
                end
            end
            default: state_n = IDLE;
        endcase

        if (wr_ctrl) begin
            ctrl_en_n = timerwdata[0];
            ctrl_ar_n = timerwdata[1];
            if (timerwdata[2]) begin
                count_n = reload_q;
                presc_n = 16'h0000;
            end
        end

        // Expiry sets the flag even when STATUS is read on the same edge;
        // a miss is only counted against a flag nobody has consumed.
        if (expire) begin
            timeout_n = 1'b1;
            expired_n = 1'b1;
            if (expired_q && !rd_status && (miss_q != 8'hFF)) begin
                miss_n = miss_q + 8'd1;
            end
        end
    end

    // Combinational read mux so a single-cycle load sees data in the same cycle.
    always_comb begin
        timerrdata = 16'h0000;
        if (timercs && timerread) begin
            unique case (timeraddr)
                ADDR_CTRL:   timerrdata = {14'h0000, ctrl_ar, ctrl_en};
                ADDR_RELOAD: timerrdata = reload_q;
                ADDR_COUNT:  timerrdata = count_q;
                ADDR_STATUS: timerrdata = {miss_q, 6'b000000, running, expired_q};
                default:     timerrdata = 16'h0000;
            endcase
        end
    end

endmodule

// File: tb/tb_io_timer.sv
// tb/tb_io_timer.sv - directed table-driven bench for io_timer
module tb_io_timer;

    logic        clock;
    logic        rst;
    logic        cs4, cs1;
    logic [1:0]  addr;
    logic        rd, wr;
    logic [15:0] wdata;
    logic [15:0] rdata4, rdata1;
    logic        to4, to1;
    logic        run4, run1;

    int checks = 0;
    int errors = 0;

    localparam logic [1:0] A_CTRL = 2'd0, A_RELOAD = 2'd1, A_COUNT = 2'd2, A_STATUS = 2'd3;

    io_timer #(.PRESCALE(4)) u_dut4 (
        .clock(clock), .rst(rst), .timercs(cs4), .timeraddr(addr),
        .timerread(rd), .timerwrite(wr), .timerwdata(wdata),
        .timerrdata(rdata4), .timeout(to4), .running(run4)
    );

    io_timer #(.PRESCALE(1)) u_dut1 (
        .clock(clock), .rst(rst), .timercs(cs1), .timeraddr(addr),
        .timerread(rd), .timerwrite(wr), .timerwdata(wdata),
        .timerrdata(rdata1), .timeout(to1), .running(run1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        w;
        logic        r;
        logic [1:0]  a;
        logic [15:0] d;
        logic [15:0] exp_rd;
        logic        exp_to;
        logic        exp_run;
    } vec_t;

    vec_t tbl[20];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic bus_wr(input bit s, input logic [1:0] a, input logic [15:0] d);
        cs4 = !s; cs1 = s; addr = a; wdata = d; wr = 1'b1;
        @(posedge clock);
        #1;
        cs4 = 1'b0; cs1 = 1'b0; wr = 1'b0;
    endtask

    task automatic rd_chk(input bit s, input logic [1:0] a, input logic [15:0] exp, input string name);
        logic [15:0] d;
        cs4 = !s; cs1 = s; addr = a; rd = 1'b1;
        #2;
        d = s ? rdata1 : rdata4;
        chk(name, d, exp);
        @(posedge clock);
        #1;
        cs4 = 1'b0; cs1 = 1'b0; rd = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; cs4 = 1'b0; cs1 = 1'b0; addr = 2'd0; rd = 1'b0; wr = 1'b0; wdata = 16'h0;

        // One-shot countdown, one row per clock cycle.
        tbl[0]  = '{1'b1, 1'b0, A_RELOAD, 16'd3, 16'h0000, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, A_CTRL,   16'd1, 16'h0000, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, A_CTRL,   16'd0, 16'h0000, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, A_COUNT,  16'd0, 16'h0003, 1'b0, 1'b1};
        tbl[4]  = '{1'b0, 1'b0, A_CTRL,   16'd0, 16'h0000, 1'b0, 1'b1};
        tbl[5]  = '{1'b0, 1'b0, A_CTRL,   16'd0, 16'h0000, 1'b0, 1'b1};
        tbl[6]  = '{1'b0, 1'b0, A_CTRL,   16'd0, 16'h0000, 1'b0, 1'b1};
        tbl[7]  = '{1'b0, 1'b1, A_COUNT,  16'd0, 16'h0002, 1'b0, 1'b1};
        tbl[8]  = '{1'b0, 1'b0, A_CTRL,   16'd0, 16'h0000, 1'b0, 1'b1};
        tbl[9]  = '{1'b0, 1'b0, A_CTRL,   16'd0, 16'h0000, 1'b0, 1'b1};
        tbl[10] = '{1'b0, 1'b0, A_CTRL,   16'd0, 16'h0000, 1'b0, 1'b1};
        tbl[11] = '{1'b0, 1'b1, A_COUNT,  16'd0, 16'h0001, 1'b0, 1'b1};
        tbl[12] = '{1'b0, 1'b0, A_CTRL,   16'd0, 16'h0000, 1'b0, 1'b1};
        tbl[13] = '{1'b0, 1'b0, A_CTRL,   16'd0, 16'h0000, 1'b0, 1'b1};
        tbl[14] = '{1'b0, 1'b0, A_CTRL,   16'd0, 16'h0000, 1'b0, 1'b1};
        tbl[15] = '{1'b0, 1'b0, A_CTRL,   16'd0, 16'h0000, 1'b1, 1'b0};
        tbl[16] = '{1'b0, 1'b1, A_STATUS, 16'd0, 16'h0001, 1'b0, 1'b0};
        tbl[17] = '{1'b0, 1'b1, A_STATUS, 16'd0, 16'h0000, 1'b0, 1'b0};
        tbl[18] = '{1'b0, 1'b1, A_CTRL,   16'd0, 16'h0000, 1'b0, 1'b0};
        tbl[19] = '{1'b0, 1'b1, A_COUNT,  16'd0, 16'h0000, 1'b0, 1'b0};

        // Reset state
        cyc();
        chk("reset_timeout", 16'(to4), 16'h0);
        chk("reset_running", 16'(run4), 16'h0);
        for (int i = 0; i < 4; i++) begin
            cs4 = 1'b1; rd = 1'b1; addr = 2'(i);
            #1;
            chk($sformatf("reset_reg%0d", i), rdata4, 16'h0000);
        end
        cs4 = 1'b0; rd = 1'b0;
        rst = 1'b0;
        cyc();

        // Table: RELOAD=3, enable, count 3,2,1, single timeout, status clear
        for (int i = 0; i < 20; i++) begin
            cs4 = tbl[i].w | tbl[i].r; addr = tbl[i].a; wr = tbl[i].w; rd = tbl[i].r; wdata = tbl[i].d;
            #2;
            chk($sformatf("t1_row%0d_rdata", i), rdata4, tbl[i].exp_rd);
            chk($sformatf("t1_row%0d_timeout", i), 16'(to4), 16'(tbl[i].exp_to));
            chk($sformatf("t1_row%0d_running", i), 16'(run4), 16'(tbl[i].exp_run));
            @(posedge clock);
            #1;
            cs4 = 1'b0; wr = 1'b0; rd = 1'b0;
        end

        // Autoreload: timeout every 8 cycles, misses accumulate without reads
        bus_wr(0, A_RELOAD, 16'd2);
        bus_wr(0, A_CTRL, 16'h0003);
        for (int k = 1; k <= 33; k++) begin
            cyc();
            chk($sformatf("t2_timeout_k%0d", k), 16'(to4),
                16'((k >= 9) && ((k - 9) % 8 == 0)));
        end
        rd_chk(0, A_STATUS, 16'h0303, "t2_status_4exp");
        rd_chk(0, A_STATUS, 16'h0002, "t2_status_cleared");
        bus_wr(0, A_CTRL, 16'h0000);

        // PRESCALE=1: expiry every cycle, miss saturates at 255
        bus_wr(1, A_RELOAD, 16'd1);
        bus_wr(1, A_CTRL, 16'h0003);
        cyc();
        chk("t3_run", 16'(run1), 16'h1);
        chk("t3_to_first", 16'(to1), 16'h0);
        cyc();
        chk("t3_to_e2", 16'(to1), 16'h1);
        cyc();
        chk("t3_to_e3", 16'(to1), 16'h1);
        for (int k = 0; k < 300; k++) cyc();
        rd_chk(1, A_STATUS, 16'hFF03, "t3_miss_sat");
        bus_wr(1, A_CTRL, 16'h0000);
        chk("t3_pause_no_to", 16'(to1), 16'h0);
        chk("t3_pause_run", 16'(run1), 16'h0);
        rd_chk(1, A_STATUS, 16'h0001, "t3_collision_status");

        // Pause and resume
        bus_wr(0, A_RELOAD, 16'd10);
        bus_wr(0, A_CTRL, 16'h0005);
        for (int k = 0; k < 21; k++) cyc();
        rd_chk(0, A_COUNT, 16'd5, "t4_count_5ticks");
        bus_wr(0, A_CTRL, 16'h0000);
        for (int k = 0; k < 20; k++) begin
            chk($sformatf("t4_paused_run_%0d", k), 16'(run4), 16'h0);
            rd_chk(0, A_COUNT, 16'd5, $sformatf("t4_hold_%0d", k));
        end
        bus_wr(0, A_CTRL, 16'h0001);
        for (int k = 1; k <= 22; k++) begin
            cyc();
            chk($sformatf("t4_resume_to_k%0d", k), 16'(to4), 16'(k == 21));
        end
        rd_chk(0, A_STATUS, 16'h0001, "t4_status");

        // RELOAD=0 enable expires at once; load with enable clear stays idle
        bus_wr(0, A_RELOAD, 16'd0);
        bus_wr(0, A_CTRL, 16'h0001);
        chk("t5_to_before", 16'(to4), 16'h0);
        cyc();
        chk("t5_to_pulse", 16'(to4), 16'h1);
        chk("t5_never_run", 16'(run4), 16'h0);
        cyc();
        chk("t5_to_end", 16'(to4), 16'h0);
        rd_chk(0, A_STATUS, 16'h0001, "t5_status");
        rd_chk(0, A_CTRL, 16'h0000, "t5_ctrl_en_clr");
        bus_wr(0, A_RELOAD, 16'd7);
        bus_wr(0, A_CTRL, 16'h0004);
        rd_chk(0, A_COUNT, 16'd7, "t5_load_count");
        chk("t5_load_idle", 16'(run4), 16'h0);
        rd_chk(0, A_CTRL, 16'h0000, "t5_load_selfclr");

        // STATUS read on the expiry edge
        bus_wr(0, A_RELOAD, 16'd1);
        bus_wr(0, A_CTRL, 16'h0005);
        for (int k = 0; k < 4; k++) cyc();
        rd_chk(0, A_STATUS, 16'h0002, "t6_read_on_expiry");
        chk("t6_to", 16'(to4), 16'h1);
        rd_chk(0, A_STATUS, 16'h0001, "t6_set_wins");

        // Asynchronous reset mid-run
        bus_wr(1, A_CTRL, 16'h0003);
        bus_wr(0, A_RELOAD, 16'd9);
        bus_wr(0, A_CTRL, 16'h0005);
        for (int k = 0; k < 3; k++) cyc();
        chk("t7_pre_run", 16'(run4), 16'h1);
        chk("t7_pre_to1", 16'(to1), 16'h1);
        cs4 = 1'b1; rd = 1'b1; addr = A_COUNT;
        #1;
        chk("t7_pre_count", rdata4, 16'd9);
        rst = 1'b1;
        #1;
        chk("t7_rst_count", rdata4, 16'h0000);
        chk("t7_rst_run", 16'(run4), 16'h0);
        chk("t7_rst_to4", 16'(to4), 16'h0);
        chk("t7_rst_to1", 16'(to1), 16'h0);
        chk("t7_rst_run1", 16'(run1), 16'h0);
        cs4 = 1'b0; rd = 1'b0;
        cyc();
        rst = 1'b0;
        cyc();
        chk("t7_post_run", 16'(run4), 16'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
